ft245_tx_framer: RTL and testbench

FT245_TX_FRAMER -- requirements
Module: ft245_tx_framer

---
 rtl/ft245_tx_framer.sv | 168 ++++++++++++++++
 tb/tb_ft245_tx_framer.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ft245_tx_framer.sv
// Frames an upstream byte stream into SYNC/seq/payload/checksum packets and
// writes them to an FT2232/FT232H synchronous FIFO through a one-byte holding register.
module ft245_tx_framer #(
    parameter int unsigned PAYLOAD = 5,
    parameter logic [7:0]  SYNC    = 8'hA5,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        oclk,
    input  logic        rst_n,
    input  logic        itvalid,
    input  logic [7:0]  itdata,
    output logic        itready,
    input  logic        ft_txe_n,
    output logic        ft_wr_n,
    output logic [7:0]  ft_data,
    output logic        ft_rd_n,
    output logic        ft_oe_n,
    output logic [15:0] pkt_cnt,
    output logic        pad_flag
);

    localparam logic [7:0]  PAY_LAST = 8'(PAYLOAD - 1);
    localparam logic [15:0] TO_ARM   = 16'(TIMEOUT - 2);
    localparam logic [7:0]  PAD_BYTE = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        SEQ,
        PAY,
        CSUM
    } state_t;

    state_t      state_q, state_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  ft_data_q, ft_data_d;
    logic [7:0]  seq_q, seq_d;
    logic [7:0]  csum_q, csum_d;
    logic [15:0] pkt_cnt_q, pkt_cnt_d;
    logic        pad_q, pad_d;
    logic [15:0] tmo_q, tmo_d;
    logic [7:0]  pay_cnt_q, pay_cnt_d;

    logic slot_free;
    logic xfer;
    logic pay_load;

    // A byte leaves the holding register on any edge where it is valid and
    // the FTDI FIFO has room, so the slot can be refilled on that same edge.
    assign xfer      = out_valid_q & ~ft_txe_n;
    assign slot_free = ~out_valid_q | ~ft_txe_n;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q & ~xfer;
        ft_data_d   = ft_data_q;
        seq_d       = seq_q;
        csum_d      = csum_q;
        pkt_cnt_d   = pkt_cnt_q;
        pad_d       = pad_q;
        tmo_d       = tmo_q;
        pay_cnt_d   = pay_cnt_q;
        itready     = 1'b0;
        pay_load    = 1'b0;

        case (state_q)
            IDLE: begin
                if (itvalid && slot_free) begin
                    ft_data_d   = SYNC;
                    out_valid_d = 1'b1;
                    state_d     = HDR;
                end
            end

            HDR: begin
                if (slot_free) begin
                    ft_data_d   = seq_q;
                    out_valid_d = 1'b1;
                    csum_d      = seq_q;
                    state_d     = SEQ;
                end
            end

            // SEQ already accepts the first payload byte so the packet is
            // written without a bubble after the seq byte.
            SEQ, PAY: begin
                if (slot_free) begin
                    state_d = PAY;
                    if (pad_q) begin
                        ft_data_d   = PAD_BYTE;
                        out_valid_d = 1'b1;
                        csum_d      = csum_q ^ PAD_BYTE;
                        pay_load    = 1'b1;
                    end else if (itvalid) begin
                        itready     = 1'b1;
                        ft_data_d   = itdata;
                        out_valid_d = 1'b1;
                        csum_d      = csum_q ^ itdata;
                        tmo_d       = 16'd0;
                        pay_load    = 1'b1;
                    end else begin
                        if (tmo_q == TO_ARM) begin
                            pad_d = 1'b1;
                        end
                        tmo_d = tmo_q + 16'd1;
                    end

                    if (pay_load) begin
                        if (pay_cnt_q == PAY_LAST) begin
                            pay_cnt_d = 8'd0;
                            tmo_d     = 16'd0;
                            state_d   = CSUM;
                        end else begin
                            pay_cnt_d = pay_cnt_q + 8'd1;
                        end
                    end
                end
            end

            CSUM: begin
                if (slot_free) begin
                    ft_data_d   = csum_q;
                    out_valid_d = 1'b1;
                    seq_d       = seq_q + 8'd1;
                    pkt_cnt_d   = pkt_cnt_q + 16'd1;
                    pad_d       = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge oclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            ft_data_q   <= 8'd0;
            seq_q       <= 8'd0;
            csum_q      <= 8'd0;
            pkt_cnt_q   <= 16'd0;
            pad_q       <= 1'b0;
            tmo_q       <= 16'd0;
            pay_cnt_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            ft_data_q   <= ft_data_d;
            seq_q       <= seq_d;
            csum_q      <= csum_d;
            pkt_cnt_q   <= pkt_cnt_d;
            pad_q       <= pad_d;
            tmo_q       <= tmo_d;
            pay_cnt_q   <= pay_cnt_d;
        end
    end

    assign ft_wr_n  = ~out_valid_q;
    assign ft_data  = ft_data_q;
    assign ft_rd_n  = 1'b1;
    assign ft_oe_n  = 1'b1;
    assign pkt_cnt  = pkt_cnt_q;
    assign pad_flag = pad_q;

endmodule

// File: tb/tb_ft245_tx_framer.sv
// Self-checking bench for ft245_tx_framer: directed packets plus randomized
// traffic compared against a packet-level reference model.
`timescale 1ns/1ps
module tb_ft245_tx_framer;

    localparam int         PAYLOAD = 5;
    localparam logic [7:0] SYNC    = 8'hA5;
    localparam int         TIMEOUT = 8;
    localparam int         PKT_LEN = PAYLOAD + 3;

    logic        oclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        itvalid = 1'b0;
    logic [7:0]  itdata = 8'd0;
    logic        itready;
    logic        ft_txe_n = 1'b1;
    logic        ft_wr_n;
    logic [7:0]  ft_data;
    logic        ft_rd_n;
    logic        ft_oe_n;
    logic [15:0] pkt_cnt;
    logic        pad_flag;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int txe_mode = 0;
    int rdy_cnt = 0;

    logic [7:0] obs_q[$];
    int         obs_cyc[$];
    logic       obs_pad[$];
    logic [7:0] exp_q[$];

    ft245_tx_framer #(
        .PAYLOAD (PAYLOAD),
        .SYNC    (SYNC),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .oclk     (oclk),
        .rst_n    (rst_n),
        .itvalid  (itvalid),
        .itdata   (itdata),
        .itready  (itready),
        .ft_txe_n (ft_txe_n),
        .ft_wr_n  (ft_wr_n),
        .ft_data  (ft_data),
        .ft_rd_n  (ft_rd_n),
        .ft_oe_n  (ft_oe_n),
        .pkt_cnt  (pkt_cnt),
        .pad_flag (pad_flag)
    );

    always #5 oclk = ~oclk;

    always @(posedge oclk) cyc <= cyc + 1;

    // FTDI full flag: 0 = always room, 1 = random backpressure, 2 = held full
    always @(posedge oclk) begin
        #2;
        case (txe_mode)
            1:       ft_txe_n = ($urandom_range(0, 3) == 0);
            2:       ft_txe_n = 1'b1;
            default: ft_txe_n = 1'b0;
        endcase
    end

    // Transfers are decided by values stable at the falling edge
    always @(negedge oclk) begin
        if (rst_n && !ft_wr_n && !ft_txe_n) begin
            obs_q.push_back(ft_data);
            obs_cyc.push_back(cyc);
            obs_pad.push_back(pad_flag);
        end
        if (rst_n && itready) rdy_cnt++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Reference model: one packet from its payload bytes, padded with FF.
    function automatic void model_packet(input logic [7:0] pay[$], input logic [7:0] seq);
        logic [7:0] c;
        logic [7:0] b;
        c = seq;
        exp_q.push_back(SYNC);
        exp_q.push_back(seq);
        for (int i = 0; i < PAYLOAD; i++) begin
            b = (i < pay.size()) ? pay[i] : 8'hFF;
            exp_q.push_back(b);
            c = c ^ b;
        end
        exp_q.push_back(c);
    endfunction

    task automatic clear_obs();
        obs_q.delete();
        obs_cyc.delete();
        obs_pad.delete();
        exp_q.delete();
        rdy_cnt = 0;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        itvalid  = 1'b0;
        txe_mode = 0;
        repeat (3) @(posedge oclk);
        #1;
        clear_obs();
        rst_n = 1'b1;
    endtask

    task automatic feed(input logic [7:0] bytes[$], input int gap_max);
        for (int i = 0; i < bytes.size(); i++) begin
            int g;
            bit ok;
            g = 0;
            if (gap_max > 0 && $urandom_range(0, 3) == 0) g = int'($urandom_range(1, gap_max));
            if (g > 0) begin
                itvalid = 1'b0;
                repeat (g) begin @(posedge oclk); #1; end
            end
            itvalid = 1'b1;
            itdata  = bytes[i];
            ok = 1'b0;
            for (int w = 0; w < 300 && !ok; w++) begin
                @(negedge oclk);
                if (itready) ok = 1'b1;
                @(posedge oclk); #1;
            end
            if (!ok) begin
                tests++; fails++;
                $display("FAIL feed_accept byte %0d: itready stayed 0, required acceptance within 300 cycles", i);
            end
        end
        itvalid = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int w = 0; w < budget && !ok; w++) begin
            if (obs_q.size() >= n) ok = 1'b1;
            else begin @(posedge oclk); #1; end
        end
    endtask

    task automatic rand_bytes(input int n, output logic [7:0] q[$]);
        q.delete();
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        itvalid = 1'b1;
        itdata  = 8'h55;
        repeat (2) @(posedge oclk);
        @(negedge oclk);
        tests++; if (ft_wr_n !== 1'b1) begin fails++; $display("FAIL reset_wr_n: got %b want 1", ft_wr_n); end
        tests++; if (ft_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h want 00", ft_data); end
        tests++; if (itready !== 1'b0) begin fails++; $display("FAIL reset_itready: got %b want 0", itready); end
        tests++; if (pkt_cnt !== 16'd0) begin fails++; $display("FAIL reset_pkt_cnt: got %0d want 0", pkt_cnt); end
        tests++; if (pad_flag !== 1'b0) begin fails++; $display("FAIL reset_pad: got %b want 0", pad_flag); end
        tests++; if ({ft_rd_n, ft_oe_n} !== 2'b11) begin fails++; $display("FAIL reset_rd_oe: got %b want 11", {ft_rd_n, ft_oe_n}); end
        itvalid = 1'b0;
        @(posedge oclk); #1;
        clear_obs();
        rst_n = 1'b1;
        repeat (3) @(posedge oclk);
        #1;
        tests++; if (ft_wr_n !== 1'b1) begin fails++; $display("FAIL idle_wr_n: got %b want 1 with no input", ft_wr_n); end
        $display("[TB] reset: checks done");
    endtask

    task automatic test_basic();
        logic [7:0] q[$];
        logic [7:0] exp8 [8];
        logic [7:0] got;
        bit ok;
        do_reset();
        exp8 = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h01};
        q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        feed(q, 0);
        wait_bytes(8, 200, ok);
        tests++; if (!ok) begin fails++; $display("FAIL basic_count: got %0d bytes want 8", obs_q.size()); end
        for (int i = 0; i < 8; i++) begin
            got = (i < obs_q.size()) ? obs_q[i] : 8'hxx;
            tests++; if (got !== exp8[i]) begin fails++; $display("FAIL basic_byte%0d: got %h want %h", i, got, exp8[i]); end
        end
        tests++;
        if (obs_cyc.size() < 8 || obs_cyc[7] - obs_cyc[0] != 7) begin
            fails++; $display("FAIL basic_consecutive: write edges not 8 consecutive (n=%0d)", obs_cyc.size());
        end
        repeat (4) @(posedge oclk); #1;
        tests++; if (pkt_cnt !== 16'd1) begin fails++; $display("FAIL basic_pkt_cnt: got %0d want 1", pkt_cnt); end
        tests++; if (obs_q.size() != 8) begin fails++; $display("FAIL basic_extra: got %0d writes want 8", obs_q.size()); end
        $display("[TB] basic packet: %0d bytes written, pkt_cnt=%0d", obs_q.size(), pkt_cnt);
    endtask

    task automatic test_txe_stall();
        logic [7:0] q[$];
        logic [7:0] exp8 [8];
        logic [7:0] got;
        bit ok;
        bit found;
        do_reset();
        exp8 = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h01};
        q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        found = 1'b0;
        fork
            feed(q, 0);
            begin
                for (int w = 0; w < 100 && !found; w++) begin
                    @(posedge oclk); #1;
                    if (!ft_wr_n && ft_data == 8'h03) found = 1'b1;
                end
                if (found) begin
                    txe_mode = 2;
                    for (int k = 0; k < 3; k++) begin
                        @(negedge oclk);
                        tests++;
                        if (ft_data !== 8'h03 || ft_wr_n !== 1'b0) begin
                            fails++; $display("FAIL stall_hold%0d: got data %h wr_n %b want 03/0", k, ft_data, ft_wr_n);
                        end
                        @(posedge oclk); #1;
                    end
                    txe_mode = 0;
                end else begin
                    tests++; fails++;
                    $display("FAIL stall_find: byte 03 never presented, required within 100 cycles");
                end
            end
        join
        wait_bytes(8, 200, ok);
        tests++; if (!ok) begin fails++; $display("FAIL stall_count: got %0d bytes want 8", obs_q.size()); end
        for (int i = 0; i < 8; i++) begin
            got = (i < obs_q.size()) ? obs_q[i] : 8'hxx;
            tests++; if (got !== exp8[i]) begin fails++; $display("FAIL stall_byte%0d: got %h want %h", i, got, exp8[i]); end
        end
        repeat (3) @(posedge oclk); #1;
        tests++; if (obs_q.size() != 8) begin fails++; $display("FAIL stall_dup: got %0d writes want 8", obs_q.size()); end
        $display("[TB] txe stall packet: %0d bytes written", obs_q.size());
    endtask

    task automatic test_timeout();
        logic [7:0] q[$];
        logic [7:0] exp8 [8];
        logic [7:0] got;
        bit ok;
        do_reset();
        exp8 = '{8'hA5, 8'h00, 8'h10, 8'h20, 8'hFF, 8'hFF, 8'hFF, 8'hCF};
        q = {8'h10, 8'h20};
        feed(q, 0);
        repeat (TIMEOUT - 2) @(posedge oclk);
        #1;
        tests++; if (pad_flag !== 1'b0) begin fails++; $display("FAIL pad_early: got %b want 0 after %0d idle edges", pad_flag, TIMEOUT - 2); end
        @(posedge oclk); #1;
        tests++; if (pad_flag !== 1'b1) begin fails++; $display("FAIL pad_set: got %b want 1 after %0d idle edges", pad_flag, TIMEOUT - 1); end
        wait_bytes(8, 200, ok);
        tests++; if (!ok) begin fails++; $display("FAIL pad_count: got %0d bytes want 8", obs_q.size()); end
        for (int i = 0; i < 8; i++) begin
            got = (i < obs_q.size()) ? obs_q[i] : 8'hxx;
            tests++; if (got !== exp8[i]) begin fails++; $display("FAIL pad_byte%0d: got %h want %h", i, got, exp8[i]); end
        end
        for (int i = 4; i < 8; i++) begin
            tests++;
            if (i >= obs_pad.size() || obs_pad[i] !== (i < 7)) begin
                fails++; $display("FAIL pad_flag_byte%0d: got %b want %b", i, (i < obs_pad.size()) ? obs_pad[i] : 1'bx, (i < 7));
            end
        end
        tests++; if (pad_flag !== 1'b0) begin fails++; $display("FAIL pad_clear: got %b want 0", pad_flag); end
        $display("[TB] timeout packet: padded, %0d bytes written", obs_q.size());
        clear_obs();
        rand_bytes(PAYLOAD, q);
        model_packet(q, 8'h01);
        feed(q, 0);
        wait_bytes(PKT_LEN, 200, ok);
        tests++;
        if (!ok || obs_q != exp_q) begin
            fails++; $display("FAIL pad_next_pkt: got %p want %p", obs_q, exp_q);
        end
        $display("[TB] packet after padding: seq %h", (obs_q.size() > 1) ? obs_q[1] : 8'hxx);
    endtask

    task automatic test_seq_wrap();
        logic [7:0] all_b[$];
        logic [7:0] pkt[$];
        bit ok;
        bit bad;
        int base;
        do_reset();
        txe_mode = 1;
        all_b.delete();
        for (int p = 0; p < 257; p++) begin
            rand_bytes(PAYLOAD, pkt);
            model_packet(pkt, 8'(p));
            all_b = {all_b, pkt};
        end
        feed(all_b, TIMEOUT - 3);
        wait_bytes(257 * PKT_LEN, 400, ok);
        txe_mode = 0;
        tests++; if (!ok) begin fails++; $display("FAIL wrap_count: got %0d bytes want %0d", obs_q.size(), 257 * PKT_LEN); end
        for (int p = 0; p < 257; p++) begin
            base = p * PKT_LEN;
            bad  = 1'b0;
            for (int j = 0; j < PKT_LEN; j++) begin
                if (base + j >= obs_q.size() || obs_q[base + j] !== exp_q[base + j]) bad = 1'b1;
            end
            tests++;
            if (bad) begin
                fails++; $display("FAIL wrap_pkt%0d: observed bytes differ from model (seq want %h)", p, exp_q[base + 1]);
            end else begin
                $display("[TB] wrap pkt %0d seq %h csum %h", p, obs_q[base + 1], obs_q[base + PKT_LEN - 1]);
            end
        end
        tests++;
        if (obs_q.size() <= 256 * PKT_LEN + 1 || obs_q[256 * PKT_LEN + 1] !== 8'h00) begin
            fails++; $display("FAIL wrap_seq256: packet 256 seq not 00");
        end
        repeat (3) @(posedge oclk); #1;
        tests++; if (pkt_cnt !== 16'd257) begin fails++; $display("FAIL wrap_pkt_cnt: got %0d want 257", pkt_cnt); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] q[$];
        bit ok;
        do_reset();
        rand_bytes(2, q);
        feed(q, 0);
        itvalid = 1'b1;
        rst_n   = 1'b0;
        #1;
        tests++; if (ft_wr_n !== 1'b1) begin fails++; $display("FAIL midrst_wr_n: got %b want 1", ft_wr_n); end
        tests++; if (itready !== 1'b0) begin fails++; $display("FAIL midrst_itready: got %b want 0", itready); end
        tests++; if (pkt_cnt !== 16'd0) begin fails++; $display("FAIL midrst_pkt_cnt: got %0d want 0", pkt_cnt); end
        itvalid = 1'b0;
        repeat (2) @(posedge oclk);
        #1;
        clear_obs();
        rst_n = 1'b1;
        rand_bytes(PAYLOAD, q);
        model_packet(q, 8'h00);
        feed(q, 0);
        wait_bytes(PKT_LEN, 200, ok);
        tests++;
        if (!ok || obs_q != exp_q) begin
            fails++; $display("FAIL midrst_pkt: got %p want %p", obs_q, exp_q);
        end
        $display("[TB] reset mid-packet: new packet seq %h", (obs_q.size() > 1) ? obs_q[1] : 8'hxx);
    endtask

    task automatic test_back_to_back();
        logic [7:0] q[$];
        logic [7:0] p0[$];
        logic [7:0] p1[$];
        bit ok;
        do_reset();
        rand_bytes(2 * PAYLOAD, q);
        p0 = q[0:PAYLOAD-1];
        p1 = q[PAYLOAD:2*PAYLOAD-1];
        model_packet(p0, 8'h00);
        model_packet(p1, 8'h01);
        feed(q, 0);
        wait_bytes(2 * PKT_LEN, 200, ok);
        repeat (3) @(posedge oclk); #1;
        tests++;
        if (!ok || obs_q != exp_q) begin
            fails++; $display("FAIL b2b_stream: got %p want %p", obs_q, exp_q);
        end
        tests++;
        if (obs_cyc.size() != 2 * PKT_LEN || obs_cyc[2 * PKT_LEN - 1] - obs_cyc[0] != 2 * PKT_LEN - 1) begin
            fails++; $display("FAIL b2b_consecutive: %0d writes not back to back, want %0d", obs_cyc.size(), 2 * PKT_LEN);
        end
        tests++; if (rdy_cnt != 2 * PAYLOAD) begin fails++; $display("FAIL b2b_itready: got %0d edges want %0d", rdy_cnt, 2 * PAYLOAD); end
        tests++; if (pkt_cnt !== 16'd2) begin fails++; $display("FAIL b2b_pkt_cnt: got %0d want 2", pkt_cnt); end
        $display("[TB] back to back: %0d writes, %0d itready edges", obs_q.size(), rdy_cnt);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_txe_stall();
        test_timeout();
        test_seq_wrap();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
